axis_credit_tx: RTL and testbench

//  Transmit end of a credit-flow AXI-Stream link. Accepts standard valid/ready AXI-Stream
//  and drives a registered valid-only output (no m_axis_tready) into long pipelined

---
 rtl/axis_credit_tx.sv | 123 ++++++++++++
 tb/tb_axis_credit_tx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_credit_tx.sv
// Credit-flow AXI-Stream transmitter: forwards accepted beats as one-cycle valid pulses
// and throttles the input so the far-end buffer of CREDIT_INIT beats can never overflow.
module axis_credit_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int KEEP_ENABLE  = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
  parameter int LAST_ENABLE  = 1,
  parameter int ID_ENABLE    = 0,
  parameter int ID_WIDTH     = 8,
  parameter int DEST_ENABLE  = 0,
  parameter int DEST_WIDTH   = 8,
  parameter int USER_ENABLE  = 1,
  parameter int USER_WIDTH   = 1,
  parameter int CREDIT_INIT  = 16,
  parameter int CREDIT_WIDTH = $clog2(CREDIT_INIT + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [ID_WIDTH-1:0]     s_axis_tid,
  input  logic [DEST_WIDTH-1:0]   s_axis_tdest,
  input  logic [USER_WIDTH-1:0]   s_axis_tuser,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  output logic [ID_WIDTH-1:0]     m_axis_tid,
  output logic [DEST_WIDTH-1:0]   m_axis_tdest,
  output logic [USER_WIDTH-1:0]   m_axis_tuser,
  input  logic                    credit_return_valid,
  input  logic [CREDIT_WIDTH-1:0] credit_return_count,
  output logic [CREDIT_WIDTH-1:0] credit_count,
  output logic                    credit_overflow
);

  localparam logic [CREDIT_WIDTH:0]   CREDIT_MAX = (CREDIT_WIDTH + 1)'(CREDIT_INIT);
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_RST = CREDIT_WIDTH'(CREDIT_INIT);

  logic                    ready_r;
  logic                    valid_r;
  logic                    overflow_r;
  logic [CREDIT_WIDTH-1:0] credit_r;
  logic [DATA_WIDTH-1:0]   data_r;
  logic [KEEP_WIDTH-1:0]   keep_r;
  logic                    last_r;
  logic [ID_WIDTH-1:0]     id_r;
  logic [DEST_WIDTH-1:0]   dest_r;
  logic [USER_WIDTH-1:0]   user_r;

  logic                    send_s;
  logic                    over_s;
  logic [CREDIT_WIDTH:0]   ret_s;
  logic [CREDIT_WIDTH:0]   sum_s;
  logic [CREDIT_WIDTH-1:0] credit_next_s;

  // One extra bit on the sum so an over-generous return is detected before clamping.
  always_comb begin
    send_s        = s_axis_tvalid & ready_r;
    ret_s         = {(CREDIT_WIDTH + 1){1'b0}};
    over_s        = 1'b0;
    credit_next_s = credit_r;
    if (credit_return_valid) begin
      ret_s = {1'b0, credit_return_count};
    end else begin
      ret_s = {(CREDIT_WIDTH + 1){1'b0}};
    end
    sum_s = {1'b0, credit_r} - {{CREDIT_WIDTH{1'b0}}, send_s} + ret_s;
    if (sum_s > CREDIT_MAX) begin
      over_s        = 1'b1;
      credit_next_s = CREDIT_RST;
    end else begin
      over_s        = 1'b0;
      credit_next_s = sum_s[CREDIT_WIDTH-1:0];
    end
  end

  // Credit counter, ready and output beat registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_r    <= 1'b0;
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
      credit_r   <= CREDIT_RST;
      data_r     <= {DATA_WIDTH{1'b0}};
      keep_r     <= {KEEP_WIDTH{1'b0}};
      last_r     <= 1'b0;
      id_r       <= {ID_WIDTH{1'b0}};
      dest_r     <= {DEST_WIDTH{1'b0}};
      user_r     <= {USER_WIDTH{1'b0}};
    end else begin
      ready_r    <= (credit_next_s != {CREDIT_WIDTH{1'b0}});
      valid_r    <= send_s;
      overflow_r <= over_s;
      credit_r   <= credit_next_s;
      if (send_s) begin
        data_r <= s_axis_tdata;
        keep_r <= s_axis_tkeep;
        last_r <= s_axis_tlast;
        id_r   <= s_axis_tid;
        dest_r <= s_axis_tdest;
        user_r <= s_axis_tuser;
      end
    end
  end

  assign s_axis_tready   = ready_r;
  assign m_axis_tvalid   = valid_r;
  assign m_axis_tdata    = data_r;
  assign credit_count    = credit_r;
  assign credit_overflow = overflow_r;

  // Disabled sideband fields are tied to their fixed values.
  assign m_axis_tkeep = (KEEP_ENABLE != 0) ? keep_r : {KEEP_WIDTH{1'b1}};
  assign m_axis_tlast = (LAST_ENABLE != 0) ? last_r : 1'b1;
  assign m_axis_tid   = (ID_ENABLE   != 0) ? id_r   : {ID_WIDTH{1'b0}};
  assign m_axis_tdest = (DEST_ENABLE != 0) ? dest_r : {DEST_WIDTH{1'b0}};
  assign m_axis_tuser = (USER_ENABLE != 0) ? user_r : {USER_WIDTH{1'b0}};

endmodule

// File: tb/tb_axis_credit_tx.sv
// Bench for axis_credit_tx: integer credit model plus a 4-deep far-end receiver,
// randomized traffic and a few hand-computed pins of the directed scenarios.
module tb_axis_credit_tx;
  localparam int CI = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    s_tdata = 8'h00;
  logic [0:0]    s_tkeep = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic [7:0]    s_tid = 8'h00;
  logic [7:0]    s_tdest = 8'h00;
  logic [0:0]    s_tuser = 1'b0;
  logic [7:0]    m_tdata;
  logic [0:0]    m_tkeep;
  logic          m_tvalid;
  logic          m_tlast;
  logic [7:0]    m_tid;
  logic [7:0]    m_tdest;
  logic [0:0]    m_tuser;
  logic          crv = 1'b0;
  logic [CW-1:0] crc = 3'd0;
  logic [CW-1:0] credit_count;
  logic          credit_overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axis_credit_tx #(.DATA_WIDTH(8), .CREDIT_INIT(CI)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
    .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tlast(m_tlast), .m_axis_tid(m_tid), .m_axis_tdest(m_tdest),
    .m_axis_tuser(m_tuser),
    .credit_return_valid(crv), .credit_return_count(crc),
    .credit_count(credit_count), .credit_overflow(credit_overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: credits as a plain integer, beats held in a queue.
  int        mdl_credit = CI;
  bit        mdl_tready = 1'b0;
  bit        mdl_tvalid = 1'b0;
  bit        mdl_ovf = 1'b0;
  bit [7:0]  mdl_data = 8'h00;
  bit        mdl_last = 1'b0;
  bit        mdl_user = 1'b0;
  bit        mdl_ok = 1'b0;
  bit        mdl_send;
  int        mdl_sum;
  bit [9:0]  sent_q[$];
  bit [9:0]  rx_q[$];
  bit        rx_on = 1'b0;
  int        beats_out = 0;

  assign mdl_send = s_tvalid && mdl_tready;
  assign mdl_sum  = mdl_credit - (mdl_send ? 1 : 0) + (crv ? int'(crc) : 0);

  always @(posedge clk) begin
    mdl_ok <= 1'b1;
    if (rst) begin
      mdl_credit <= CI;
      mdl_tready <= 1'b0;
      mdl_tvalid <= 1'b0;
      mdl_ovf    <= 1'b0;
      mdl_data   <= 8'h00;
      mdl_last   <= 1'b0;
      mdl_user   <= 1'b0;
      sent_q.delete();
    end else begin
      mdl_credit <= (mdl_sum > CI) ? CI : mdl_sum;
      mdl_ovf    <= (mdl_sum > CI);
      mdl_tready <= (((mdl_sum > CI) ? CI : mdl_sum) != 0);
      mdl_tvalid <= mdl_send;
      if (mdl_send) begin
        mdl_data <= s_tdata;
        mdl_last <= s_tlast;
        mdl_user <= s_tuser[0];
        sent_q.push_back({s_tuser[0], s_tlast, s_tdata});
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (mdl_ok) begin
      chk("tready", {31'd0, s_tready}, {31'd0, mdl_tready});
      chk("tvalid", {31'd0, m_tvalid}, {31'd0, mdl_tvalid});
      chk("credit_count", {29'd0, credit_count}, mdl_credit);
      chk("credit_overflow", {31'd0, credit_overflow}, {31'd0, mdl_ovf});
      chk("tdata", {24'd0, m_tdata}, {24'd0, mdl_data});
      chk("tlast", {31'd0, m_tlast}, {31'd0, mdl_last});
      chk("tuser", {31'd0, m_tuser}, {31'd0, mdl_user});
      chk("tkeep_const", {31'd0, m_tkeep}, 32'd1);
      chk("tid_const", {24'd0, m_tid}, 32'd0);
      chk("tdest_const", {24'd0, m_tdest}, 32'd0);
      if (m_tvalid === 1'b1) begin
        beats_out++;
        if (sent_q.size() == 0) begin
          chk("order_unexpected_beat", 32'd1, 32'd0);
        end else begin
          chk("order_beat", {22'd0, m_tuser, m_tlast, m_tdata}, {22'd0, sent_q.pop_front()});
        end
        if (rx_on) begin
          rx_q.push_back({m_tuser, m_tlast, m_tdata});
          chk("rx_no_overflow", {31'd0, rx_q.size() <= CI}, 32'd1);
        end
      end
      if (rx_on) chk("no_overflow_pulse", {31'd0, credit_overflow}, 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pending;
    int n;
    repeat (3) step();
    chk("reset_credit", {29'd0, credit_count}, 32'd4);
    chk("reset_tready", {31'd0, s_tready}, 32'd0);
    chk("reset_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("reset_tdata", {24'd0, m_tdata}, 32'd0);

    // 1: four credits drain on four consecutive beats
    rst = 1'b0; s_tvalid = 1'b1; s_tdata = 8'h10; s_tlast = 1'b1;
    step();
    chk("t1_ready_rise", {31'd0, s_tready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t1_beat_valid", {31'd0, m_tvalid}, 32'd1);
      chk("t1_beat_data", {24'd0, m_tdata}, 32'h10 + i);
      s_tdata = 8'h11 + 8'(i);
      s_tlast = 1'b0;
    end
    chk("t1_ready_low", {31'd0, s_tready}, 32'd0);
    chk("t1_credit_zero", {29'd0, credit_count}, 32'd0);
    step();
    chk("t1_stalled", {31'd0, m_tvalid}, 32'd0);

    // 2: return two credits, two more beats
    crv = 1'b1; crc = 3'd2;
    step();
    crv = 1'b0; crc = 3'd0;
    chk("t2_ready_back", {31'd0, s_tready}, 32'd1);
    chk("t2_credit", {29'd0, credit_count}, 32'd2);
    step();
    chk("t2_beat14", {24'd0, m_tdata}, 32'h14);
    s_tdata = 8'h15;
    step();
    chk("t2_beat15", {24'd0, m_tdata}, 32'h15);
    chk("t2_credit_zero", {29'd0, credit_count}, 32'd0);
    s_tvalid = 1'b0;

    // 3: simultaneous send and return
    crv = 1'b1; crc = 3'd2;
    step();
    s_tvalid = 1'b1; s_tdata = 8'h20; crc = 3'd1;
    step();
    chk("t3_credit_net", {29'd0, credit_count}, 32'd2);
    chk("t3_beat", {24'd0, m_tdata}, 32'h20);

    // 4: over-return clamps and pulses overflow once
    s_tvalid = 1'b0; crc = 3'd1;
    step();
    chk("t4_credit3", {29'd0, credit_count}, 32'd3);
    crc = 3'd3;
    step();
    chk("t4_clamped", {29'd0, credit_count}, 32'd4);
    chk("t4_ovf_pulse", {31'd0, credit_overflow}, 32'd1);
    crv = 1'b0; crc = 3'd0;
    step();
    chk("t4_ovf_gone", {31'd0, credit_overflow}, 32'd0);

    // 5: reset mid-stream
    s_tvalid = 1'b1; s_tdata = 8'h30;
    repeat (3) step();
    chk("t5_credit1", {29'd0, credit_count}, 32'd1);
    rst = 1'b1;
    step();
    chk("t5_rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("t5_rst_tready", {31'd0, s_tready}, 32'd0);
    chk("t5_rst_credit", {29'd0, credit_count}, 32'd4);
    rst = 1'b0;
    step();
    chk("t5_ready_resume", {31'd0, s_tready}, 32'd1);
    step();
    chk("t5_stream_resume", {31'd0, m_tvalid}, 32'd1);

    // 6: random traffic against a 4-deep receiver returning credits as it drains
    s_tvalid = 1'b0; rst = 1'b1;
    step(); step();
    rx_q.delete(); pending = 0; rx_on = 1'b1; beats_out = 0;
    rst = 1'b0;
    repeat (3000) begin
      s_tvalid = ($urandom_range(0, 99) < 60);
      s_tdata  = 8'($urandom);
      s_tlast  = 1'($urandom);
      s_tuser  = 1'($urandom);
      if (rx_q.size() > 0 && $urandom_range(0, 99) < 40) begin
        void'(rx_q.pop_front());
        pending++;
      end
      if (pending > 0 && $urandom_range(0, 1) == 1) begin
        n = $urandom_range(1, pending);
        crv = 1'b1; crc = CW'(n);
        pending -= n;
      end else begin
        crv = ($urandom_range(0, 3) == 0); crc = 3'd0;
      end
      step();
    end
    s_tvalid = 1'b0; crv = 1'b0; crc = 3'd0;
    repeat (3) step();
    chk("t6_all_beats_out", sent_q.size(), 32'd0);
    chk("t6_traffic_seen", {31'd0, beats_out > 200}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
